// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one fixed-latency single-ported memory
// between the I-side fetch port and the D-side load/store port.
module mem_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ready,
  output logic        i_valid,
  output logic [15:0] i_data,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ready,
  output logic        d_valid,
  output logic [15:0] d_rdata,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic { IDLE, BUSY } state_t;
  typedef enum logic { OWN_I, OWN_D } owner_t;

  typedef struct packed {
    owner_t      owner;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  localparam logic [3:0] LAST = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  req_t        cur;
  owner_t      last_grant;
  logic [3:0]  cnt;
  logic        grant_i, grant_d, done;

  // On contention the side that did not win last time gets the grant.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (d_req && (!i_req || last_grant == OWN_I)) grant_d = 1'b1;
      else if (i_req)                               grant_i = 1'b1;
    end
  end

  assign done    = (state == BUSY) && (cnt == LAST);
  assign i_ready = grant_i;
  assign d_ready = grant_d;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_i || grant_d) state_nxt = BUSY;
      BUSY:    if (done)               state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= '0;
      cnt        <= '0;
      last_grant <= OWN_I;
      i_valid    <= 1'b0;
      d_valid    <= 1'b0;
      i_data     <= '0;
      d_rdata    <= '0;
    end else begin
      i_valid <= done && (cur.owner == OWN_I);
      d_valid <= done && (cur.owner == OWN_D);
      if (grant_i || grant_d) begin
        cur.owner  <= grant_d ? OWN_D : OWN_I;
        cur.wr     <= grant_d & d_wr;
        cur.addr   <= grant_d ? d_addr : i_addr;
        cur.wdata  <= grant_d ? d_wdata : 16'h0000;
        last_grant <= grant_d ? OWN_D : OWN_I;
        cnt        <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 4'd1;
      end
      // Read data is only guaranteed in the final access cycle.
      if (done) begin
        if (cur.owner == OWN_I) i_data  <= mem_rdata;
        else if (!cur.wr)       d_rdata <= mem_rdata;
      end
    end
  end

  assign busy       = (state == BUSY);
  assign mem_enable = busy;
  assign mem_wr     = busy & cur.wr;
  assign mem_addr   = busy ? cur.addr  : 16'h0000;
  assign mem_wdata  = busy ? cur.wdata : 16'h0000;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LATENCY=4 instance with a memory model that
// only presents valid data in the last access cycle, plus a LATENCY=1 instance.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // LATENCY = 4 instance
  logic        i_req = 0, d_req = 0, d_wr = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic        i_ready, i_valid, d_ready, d_valid, mem_enable, mem_wr, busy;
  logic [15:0] i_data, d_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.LATENCY(4)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_valid(i_valid), .i_data(i_data),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory model: garbage except in the final enabled cycle.
  logic [15:0]  tb_mem [0:255];
  logic [255:0] wv = '0;
  logic [3:0]   en_cnt = '0;

  function automatic logic [15:0] dflt(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {a, a};
  endfunction

  always @(posedge clk) begin
    if (!mem_enable) en_cnt <= '0;
    else             en_cnt <= en_cnt + 4'd1;
    if (mem_enable && mem_wr && en_cnt == 4'd3) begin
      tb_mem[mem_addr[7:0]] <= mem_wdata;
      wv[mem_addr[7:0]]     <= 1'b1;
    end
  end

  assign mem_rdata = (mem_enable && en_cnt == 4'd3) ?
                     (wv[mem_addr[7:0]] ? tb_mem[mem_addr[7:0]] : dflt(mem_addr[7:0])) :
                     16'hDEAD;

  // LATENCY = 1 instance
  logic        i_req1 = 0, d_req1 = 0, d_wr1 = 0;
  logic [15:0] i_addr1 = 0, d_addr1 = 0, d_wdata1 = 0;
  logic        i_ready1, i_valid1, d_ready1, d_valid1, mem_enable1, mem_wr1, busy1;
  logic [15:0] i_data1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  mem_arbiter #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1), .i_ready(i_ready1), .i_valid(i_valid1), .i_data(i_data1),
    .d_req(d_req1), .d_wr(d_wr1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_ready(d_ready1), .d_valid(d_valid1), .d_rdata(d_rdata1),
    .mem_enable(mem_enable1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  assign mem_rdata1 = mem_enable1 ? {8'hA5, mem_addr1[7:0]} : 16'hDEAD;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    // Reset
    nxt(); nxt();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_en", mem_enable, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_ivalid", i_valid, 0);
    chk("rst_dvalid", d_valid, 0);
    chk("rst_idata", i_data, 0);
    chk("rst_drdata", d_rdata, 0);
    rst = 0;

    // I read of 0x0010
    nxt(); i_req = 1; i_addr = 16'h0010; #1;
    chk("t1_iready", i_ready, 1);
    chk("t1_dready", d_ready, 0);
    chk("t1_busy0", busy, 0);
    for (int k = 1; k <= 4; k++) begin
      nxt(); i_req = 0; #1;
      chk($sformatf("t1_en_%0d", k), mem_enable, 1);
      chk($sformatf("t1_busy_%0d", k), busy, 1);
      chk($sformatf("t1_addr_%0d", k), mem_addr, 16'h0010);
      chk($sformatf("t1_wr_%0d", k), mem_wr, 0);
      chk($sformatf("t1_ivalid_%0d", k), i_valid, 0);
    end
    nxt(); #1;
    chk("t1_ivalid", i_valid, 1);
    chk("t1_idata", i_data, 16'hBEEF);
    chk("t1_dvalid", d_valid, 0);
    chk("t1_en_off", mem_enable, 0);
    chk("t1_addr_off", mem_addr, 0);
    nxt(); #1;
    chk("t1_ivalid_drop", i_valid, 0);
    chk("t1_idata_hold", i_data, 16'hBEEF);

    // Contention right after reset: D first, then I
    nxt(); rst = 1;
    nxt(); rst = 0; i_req = 1; i_addr = 16'h0040; d_req = 1; d_wr = 0; d_addr = 16'h0030; #1;
    chk("t2_idata_rst", i_data, 0);
    chk("t2_dready", d_ready, 1);
    chk("t2_iready", i_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      nxt(); d_req = 0; #1;
      chk($sformatf("t2_iwait_%0d", k), i_ready, 0);
      chk($sformatf("t2_busy_%0d", k), busy, 1);
    end
    nxt(); #1;
    chk("t2_dvalid", d_valid, 1);
    chk("t2_drdata", d_rdata, 16'h3030);
    chk("t2_iready", i_ready, 1);
    for (int k = 6; k <= 9; k++) begin
      nxt(); i_req = 0; #1;
      chk($sformatf("t2_ivalid_%0d", k), i_valid, 0);
      chk($sformatf("t2_dvalid_%0d", k), d_valid, 0);
    end
    nxt(); #1;
    chk("t2_ivalid", i_valid, 1);
    chk("t2_idata", i_data, 16'h4040);
    chk("t2_dvalid_end", d_valid, 0);

    // Both held for 6 accesses: D,I,D,I,D,I every 5 cycles
    for (int c = 0; c <= 30; c++) begin
      nxt();
      if (c == 0)  begin i_req = 1; d_req = 1; end
      if (c == 30) begin i_req = 0; d_req = 0; end
      #1;
      chk($sformatf("rr_dready_%0d", c), d_ready, (c < 30 && c % 10 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("rr_iready_%0d", c), i_ready, (c < 30 && c % 10 == 5) ? 1'b1 : 1'b0);
      chk($sformatf("rr_dvalid_%0d", c), d_valid, (c > 0 && c % 10 == 5) ? 1'b1 : 1'b0);
      chk($sformatf("rr_ivalid_%0d", c), i_valid, (c > 0 && c % 10 == 0) ? 1'b1 : 1'b0);
    end

    // D write then D read-back in the valid cycle
    nxt(); d_req = 1; d_wr = 1; d_addr = 16'h0020; d_wdata = 16'h1234; #1;
    chk("t4_dready", d_ready, 1);
    for (int k = 1; k <= 4; k++) begin
      nxt(); d_req = 0; #1;
      chk($sformatf("t4_wr_%0d", k), mem_wr, 1);
      chk($sformatf("t4_addr_%0d", k), mem_addr, 16'h0020);
      chk($sformatf("t4_wdata_%0d", k), mem_wdata, 16'h1234);
    end
    nxt(); d_req = 1; d_wr = 0; d_wdata = 0; #1;
    chk("t4_dvalid", d_valid, 1);
    chk("t4_drdata_keep", d_rdata, 16'h3030);
    chk("t4_rd_ready", d_ready, 1);
    for (int k = 6; k <= 9; k++) begin
      nxt(); d_req = 0; #1;
      chk($sformatf("t4_rd_wr_%0d", k), mem_wr, 0);
    end
    nxt(); #1;
    chk("t4_rd_dvalid", d_valid, 1);
    chk("t4_rd_data", d_rdata, 16'h1234);

    // Reset in the second BUSY cycle of a D read
    nxt(); d_req = 1; d_addr = 16'h0030; #1;
    chk("t5_dready", d_ready, 1);
    nxt(); d_req = 0;
    nxt(); rst = 1; #1;
    chk("t5_busy_pre", busy, 1);
    nxt(); rst = 0; i_req = 1; i_addr = 16'h0010; #1;
    chk("t5_busy", busy, 0);
    chk("t5_en", mem_enable, 0);
    chk("t5_addr", mem_addr, 0);
    chk("t5_drdata", d_rdata, 0);
    chk("t5_idata", i_data, 0);
    chk("t5_iready", i_ready, 1);
    for (int k = 4; k <= 7; k++) begin
      nxt(); i_req = 0; #1;
      chk($sformatf("t5_dvalid_%0d", k), d_valid, 0);
      chk($sformatf("t5_ibusy_%0d", k), busy, 1);
    end
    nxt(); #1;
    chk("t5_ivalid", i_valid, 1);
    chk("t5_idata_new", i_data, 16'hBEEF);
    chk("t5_dvalid_end", d_valid, 0);

    // LATENCY=1 back-to-back I reads, period 2
    nxt(); i_req1 = 1; i_addr1 = 16'h0005; #1;
    chk("l1_iready0", i_ready1, 1);
    nxt(); i_addr1 = 16'h0006; #1;
    chk("l1_en1", mem_enable1, 1);
    chk("l1_busy1", busy1, 1);
    chk("l1_iready1", i_ready1, 0);
    nxt(); #1;
    chk("l1_ivalid2", i_valid1, 1);
    chk("l1_idata2", i_data1, 16'hA505);
    chk("l1_iready2", i_ready1, 1);
    chk("l1_en2", mem_enable1, 0);
    nxt(); i_req1 = 0; #1;
    chk("l1_en3", mem_enable1, 1);
    chk("l1_ivalid3", i_valid1, 0);
    nxt(); #1;
    chk("l1_ivalid4", i_valid1, 1);
    chk("l1_idata4", i_data1, 16'hA506);
    chk("l1_dvalid4", d_valid1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
